// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-style pipelined flash read port between two requesters.
// Optional readdatavalid timeout is compiled in when FLASH_ARB_TIMEOUT_EN is defined.
module flash_read_arbiter
`ifdef FLASH_ARB_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [22:0] addr0,
    input  logic [22:0] addr1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    output logic [3:0]  flash_mem_byteenable,
    input  logic        flash_mem_waitrequest,
    input  logic [31:0] flash_mem_readdata,
    input  logic        flash_mem_readdatavalid,
    output logic        busy
);

    localparam int unsigned AW = 23;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            last_id_q, last_id_d;
    logic            gnt_id_q, gnt_id_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic            read_q, read_d;
    logic            busy_q, busy_d;
    logic            win;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             err0_q, err0_d, err1_q, err1_d;
`endif

    // Next-state, grant and response logic
    always_comb begin
        state_d   = state_q;
        last_id_d = last_id_q;
        gnt_id_d  = gnt_id_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        win       = 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        to_d      = to_q;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Under contention the port that did not win last time goes next
                    win      = (req0 && req1) ? ~last_id_q : req1;
                    gnt_id_d = win;
                    addr_d   = win ? addr1 : addr0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!flash_mem_waitrequest) begin
                    state_d = S_WAIT;
`ifdef FLASH_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                    to_d    = 1'b0;
`endif
                end
            end
            S_WAIT: begin
                if (flash_mem_readdatavalid) begin
                    data_d  = flash_mem_readdata;
                    state_d = S_RESP;
                end
`ifdef FLASH_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        data_d  = '0;
                        to_d    = 1'b1;
                        state_d = S_RESP;
                    end
                end
`endif
            end
            S_RESP: begin
                if (gnt_id_q) begin
                    ack1_d   = 1'b1;
                    rdata1_d = data_q;
                end else begin
                    ack0_d   = 1'b1;
                    rdata0_d = data_q;
                end
`ifdef FLASH_ARB_TIMEOUT_EN
                err0_d = ~gnt_id_q & to_q;
                err1_d = gnt_id_q & to_q;
`endif
                last_id_d = gnt_id_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        read_d = (state_d == S_ISSUE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_id_q <= 1'b1;
            gnt_id_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            read_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            to_q      <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
            gnt_id_q  <= gnt_id_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            read_q    <= read_d;
            busy_q    <= busy_d;
`ifdef FLASH_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
`endif
        end
    end

    assign ack0                 = ack0_q;
    assign ack1                 = ack1_q;
    assign rdata0               = rdata0_q;
    assign rdata1               = rdata1_q;
    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = 4'hF;
    assign busy                 = busy_q;
`ifdef FLASH_ARB_TIMEOUT_EN
    assign err0                 = err0_q;
    assign err1                 = err1_q;
`else
    assign err0                 = 1'b0;
    assign err1                 = 1'b0;
`endif

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: randomized requesters and a flash slave model,
// checked against transaction-level expectations (grant order, latency, data per address).
module tb_flash_read_arbiter;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int unsigned TO_CYC = 8;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [22:0] addr0 = '0, addr1 = '0;
    logic        ack0, ack1, err0, err1, busy;
    logic [31:0] rdata0, rdata1;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic        flash_mem_waitrequest = 1'b0;
    logic [31:0] flash_mem_readdata = '0;
    logic        flash_mem_readdatavalid = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    bit model_last = 1'b1;

    // slave configuration written by tests
    int          stall_cfg = 0;
    int          delay_cfg = 0;
    bit          hold_rdv = 1'b0;
    bit          force_rdv = 1'b0;
    logic [31:0] force_data = '0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;

    // slave state
    int          stall_left = 0;
    int          pend_cnt = 0;
    bit          pending = 1'b0;
    logic [22:0] pend_addr = '0;
    logic [22:0] acc_q[$];

`ifdef FLASH_ARB_TIMEOUT_EN
    flash_read_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .req0                   (req0),
        .req1                   (req1),
        .addr0                  (addr0),
        .addr1                  (addr1),
        .ack0                   (ack0),
        .ack1                   (ack1),
        .rdata0                 (rdata0),
        .rdata1                 (rdata1),
        .err0                   (err0),
        .err1                   (err1),
        .flash_mem_read         (flash_mem_read),
        .flash_mem_address      (flash_mem_address),
        .flash_mem_byteenable   (flash_mem_byteenable),
        .flash_mem_waitrequest  (flash_mem_waitrequest),
        .flash_mem_readdata     (flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .busy                   (busy)
    );
`else
    flash_read_arbiter dut (
        .clk                    (clk),
        .reset                  (reset),
        .req0                   (req0),
        .req1                   (req1),
        .addr0                  (addr0),
        .addr1                  (addr1),
        .ack0                   (ack0),
        .ack1                   (ack1),
        .rdata0                 (rdata0),
        .rdata1                 (rdata1),
        .err0                   (err0),
        .err1                   (err1),
        .flash_mem_read         (flash_mem_read),
        .flash_mem_address      (flash_mem_address),
        .flash_mem_byteenable   (flash_mem_byteenable),
        .flash_mem_waitrequest  (flash_mem_waitrequest),
        .flash_mem_readdata     (flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .busy                   (busy)
    );
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [22:0] a);
        return {a, 9'h0} ^ 32'h9E37_79B9;
    endfunction

    // Flash controller model: stalls stall_cfg cycles, returns data delay_cfg cycles after accept
    always begin
        @(posedge clk);
        if (pending) begin
            if (pend_cnt == 0) pending = 1'b0;
            else pend_cnt--;
        end
        if (flash_mem_read && flash_mem_waitrequest) stall_left--;
        else if (!flash_mem_read) stall_left = stall_cfg;
        if (flash_mem_read && !flash_mem_waitrequest) begin
            acc_q.push_back(flash_mem_address);
            pending   = !hold_rdv;
            pend_cnt  = delay_cfg;
            pend_addr = flash_mem_address;
        end
        #2;
        flash_mem_waitrequest   = flash_mem_read && (stall_left > 0);
        flash_mem_readdatavalid = force_rdv || (pending && pend_cnt == 0);
        flash_mem_readdata      = force_rdv ? force_data : (ovr_en ? ovr_data : mem_word(pend_addr));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [35:0] got, exp;
        reset = 1'b1;
        repeat (3) step();
        exp = {1'b0, 23'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        got = {flash_mem_read, flash_mem_address, flash_mem_byteenable, ack0, ack1, err0, err1, busy, 1'b0};
        tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL reset_ctrl: got %h, expected %h", got, exp); end
        tests_run++;
        if ({rdata0, rdata1} !== 64'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h/%h, expected 0/0", rdata0, rdata1); end
        reset = 1'b0;
        model_last = 1'b1;
        step();
        tests_run++;
        if ({busy, flash_mem_read, ack0, ack1} !== 4'b0) begin
            tests_failed++; $display("FAIL idle_after_reset: got %b, expected 0000", {busy, flash_mem_read, ack0, ack1});
        end
    endtask

    task automatic test_single();
        int t0, reads, ack_cyc, acc_n;
        bit addr_bad, ack1_seen;
        logic [31:0] rd;
        logic er;
        stall_cfg = 0; delay_cfg = 0; ovr_en = 1'b1; ovr_data = 32'hA5A5_1234;
        reads = 0; ack_cyc = -1; addr_bad = 1'b0; ack1_seen = 1'b0; rd = '0; er = 1'b0;
        acc_n = acc_q.size();
        req0 = 1'b1; addr0 = 23'h000100; t0 = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (flash_mem_read) begin
                reads++;
                if (flash_mem_address !== 23'h000100) addr_bad = 1'b1;
            end
            if (ack1) ack1_seen = 1'b1;
            if (ack0 && ack_cyc < 0) begin ack_cyc = cyc; rd = rdata0; er = err0; req0 = 1'b0; end
        end
        ovr_en = 1'b0;
        model_last = 1'b0;
        tests_run++;
        if (reads != 1 || addr_bad) begin tests_failed++; $display("FAIL single_strobe: got %0d cycles (addr_bad=%0d), expected 1", reads, addr_bad); end
        tests_run++;
        if (ack_cyc != t0 + 3) begin tests_failed++; $display("FAIL single_latency: got ack at %0d, expected %0d", ack_cyc, t0 + 3); end
        tests_run++;
        if (rd !== 32'hA5A5_1234 || er !== 1'b0) begin tests_failed++; $display("FAIL single_data: got %h err %b, expected a5a51234 err 0", rd, er); end
        tests_run++;
        if (ack1_seen) begin tests_failed++; $display("FAIL single_ack1: got ack1 pulse, expected none"); end
        tests_run++;
        if (acc_q.size() <= acc_n || acc_q[acc_n] !== 23'h000100) begin
            tests_failed++; $display("FAIL single_addr: got %0d accepts, expected address 100", acc_q.size() - acc_n);
        end
        tests_run++;
        if (busy !== 1'b0 || rdata0 !== 32'hA5A5_1234) begin
            tests_failed++; $display("FAIL single_hold: got busy %b rdata0 %h, expected 0 / a5a51234", busy, rdata0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] prev0;
        int noack, t0, ack_cyc;
        logic [22:0] a;
        stall_cfg = 0; delay_cfg = 3;
        prev0 = rdata0;
        req0 = 1'b1; addr0 = 23'($urandom);
        step();
        step();
        tests_run++;
        if ({busy, flash_mem_read} !== 2'b10) begin tests_failed++; $display("FAIL mid_in_wait: got busy/read %b, expected 10", {busy, flash_mem_read}); end
        reset = 1'b1; req0 = 1'b0;
        step();
        reset = 1'b0;
        model_last = 1'b1;
        tests_run++;
        if ({busy, flash_mem_read} !== 2'b00) begin tests_failed++; $display("FAIL mid_reset: got busy/read %b, expected 00", {busy, flash_mem_read}); end
        noack = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ack0 || ack1 || busy) noack++;
        end
        tests_run++;
        if (noack != 0) begin tests_failed++; $display("FAIL mid_late_rdv: got %0d active cycles, expected 0", noack); end
        tests_run++;
        if (rdata0 !== 32'h0) begin tests_failed++; $display("FAIL mid_rdata0: got %h, expected 0 (prev %h)", rdata0, prev0); end
        delay_cfg = 0;
        a = 23'h7FFFC;
        req1 = 1'b1; addr1 = a; t0 = cyc + 1; ack_cyc = -1;
        for (int i = 0; i < 20 && ack_cyc < 0; i++) begin
            step();
            if (ack1) ack_cyc = cyc;
        end
        tests_run++;
        if (ack_cyc != t0 + 3 || rdata1 !== mem_word(a) || err1 !== 1'b0) begin
            tests_failed++; $display("FAIL mid_recover: got ack %0d data %h, expected %0d data %h", ack_cyc, rdata1, t0 + 3, mem_word(a));
        end
        req1 = 1'b0;
        model_last = 1'b1;
        step();
    endtask

    task automatic test_alternate(input int n);
        logic [22:0] a[2];
        int s, d, t_s, done, acc_n, p;
        logic [22:0] got_a;
        logic [31:0] got_d;
        s = 0; d = 0; stall_cfg = 0; delay_cfg = 0; done = 0;
        acc_n = acc_q.size();
        a[0] = 23'($urandom); a[1] = 23'($urandom);
        req0 = 1'b1; req1 = 1'b1; addr0 = a[0]; addr1 = a[1];
        t_s = cyc + 1;
        for (int g = 0; g < 400 && done < n; g++) begin
            step();
            if (ack0 || ack1) begin
                p = ack1 ? 1 : 0;
                tests_run++;
                if ({ack1, ack0} !== (model_last ? 2'b01 : 2'b10)) begin
                    tests_failed++; $display("FAIL alt_grant%0d: got acks %b, expected port %0d", done, {ack1, ack0}, !model_last);
                end
                got_d = p ? rdata1 : rdata0;
                tests_run++;
                if (got_d !== mem_word(a[p]) || (p ? err1 : err0) !== 1'b0) begin
                    tests_failed++; $display("FAIL alt_data%0d: got %h, expected %h", done, got_d, mem_word(a[p]));
                end
                tests_run++;
                if (cyc != t_s + 3 + s + d) begin
                    tests_failed++; $display("FAIL alt_latency%0d: got %0d, expected %0d", done, cyc - t_s, 3 + s + d);
                end
                got_a = (acc_q.size() > acc_n + done) ? acc_q[acc_n + done] : 'x;
                tests_run++;
                if (got_a !== a[p]) begin tests_failed++; $display("FAIL alt_addr%0d: got %h, expected %h", done, got_a, a[p]); end
                model_last = p[0];
                a[p] = 23'($urandom);
                if (p == 1) addr1 = a[1]; else addr0 = a[0];
                done++;
                s = (done < 4) ? 0 : int'($urandom_range(0, 3));
                d = (done < 4) ? 0 : int'($urandom_range(0, 3));
                stall_cfg = s; delay_cfg = d;
                t_s = cyc + 1;
                if (done == n) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tests_run++;
        if (done != n) begin tests_failed++; $display("FAIL alt_timeout: got %0d transactions, expected %0d", done, n); end
        stall_cfg = 0; delay_cfg = 0;
        step();
    endtask

    task automatic test_stall();
        int t0, reads, bad, ack_cyc;
        logic [22:0] a;
        stall_cfg = 5; delay_cfg = 0;
        a = 23'($urandom);
        req0 = 1'b1; addr0 = a; t0 = cyc + 1;
        reads = 0; bad = 0; ack_cyc = -1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (flash_mem_read) begin reads++; if (flash_mem_address !== a) bad++; end
            if (ack0 && ack_cyc < 0) begin ack_cyc = cyc; req0 = 1'b0; end
        end
        model_last = 1'b0;
        stall_cfg = 0;
        tests_run++;
        if (reads != 6 || bad != 0) begin tests_failed++; $display("FAIL stall_strobe: got %0d cycles %0d bad addr, expected 6 / 0", reads, bad); end
        tests_run++;
        if (ack_cyc != t0 + 8) begin tests_failed++; $display("FAIL stall_latency: got %0d, expected %0d", ack_cyc, t0 + 8); end
        tests_run++;
        if (rdata0 !== mem_word(a)) begin tests_failed++; $display("FAIL stall_data: got %h, expected %h", rdata0, mem_word(a)); end
    endtask

    task automatic test_back_to_back();
        int prev, t0, k;
        logic [22:0] a;
        stall_cfg = 0; delay_cfg = 0;
        a = 23'($urandom);
        req1 = 1'b1; addr1 = a; t0 = cyc + 1; prev = -1; k = 0;
        for (int g = 0; g < 60 && k < 5; g++) begin
            step();
            if (ack1) begin
                tests_run++;
                if (rdata1 !== mem_word(a)) begin tests_failed++; $display("FAIL b2b_data%0d: got %h, expected %h", k, rdata1, mem_word(a)); end
                tests_run++;
                if ((prev < 0 && cyc != t0 + 3) || (prev >= 0 && cyc - prev != 4)) begin
                    tests_failed++; $display("FAIL b2b_period%0d: got ack at %0d (prev %0d), expected period 4", k, cyc, prev);
                end
                prev = cyc; k++;
                a = 23'($urandom); addr1 = a;
                if (k == 5) req1 = 1'b0;
            end
        end
        req1 = 1'b0;
        model_last = 1'b1;
        tests_run++;
        if (k != 5) begin tests_failed++; $display("FAIL b2b_timeout: got %0d reads, expected 5", k); end
        step();
    endtask

    task automatic test_spurious_rdv();
        logic [31:0] p0, p1;
        int bad, t0, ack_cyc;
        logic [22:0] a;
        p0 = rdata0; p1 = rdata1; bad = 0;
        force_data = 32'hDEAD_BEEF; force_rdv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy || ack0 || ack1) bad++;
        end
        force_rdv = 1'b0;
        step();
        tests_run++;
        if (bad != 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL idle_rdv_state: got %0d active cycles, expected 0", bad); end
        tests_run++;
        if (rdata0 !== p0 || rdata1 !== p1) begin tests_failed++; $display("FAIL idle_rdv_data: got %h/%h, expected %h/%h", rdata0, rdata1, p0, p1); end
        stall_cfg = 3; delay_cfg = 0;
        a = 23'($urandom);
        req0 = 1'b1; addr0 = a; t0 = cyc + 1; ack_cyc = -1;
        step();
        force_rdv = 1'b1;
        step();
        step();
        force_rdv = 1'b0;
        for (int i = 0; i < 12 && ack_cyc < 0; i++) begin
            step();
            if (ack0) begin ack_cyc = cyc; req0 = 1'b0; end
        end
        req0 = 1'b0;
        model_last = 1'b0;
        stall_cfg = 0;
        tests_run++;
        if (ack_cyc != t0 + 6 || rdata0 !== mem_word(a)) begin
            tests_failed++; $display("FAIL issue_rdv: got ack %0d data %h, expected %0d data %h", ack_cyc, rdata0, t0 + 6, mem_word(a));
        end
        step();
    endtask

`ifdef FLASH_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int t0, ack_cyc;
        logic [22:0] a;
        logic [31:0] rd;
        logic er;
        stall_cfg = 0; delay_cfg = 0; hold_rdv = 1'b1;
        a = 23'($urandom);
        req0 = 1'b1; addr0 = a; t0 = cyc + 1; ack_cyc = -1; rd = 'x; er = 1'bx;
        for (int i = 0; i < 40 && ack_cyc < 0; i++) begin
            step();
            if (ack0) begin ack_cyc = cyc; rd = rdata0; er = err0; req0 = 1'b0; end
        end
        req0 = 1'b0; hold_rdv = 1'b0;
        tests_run++;
        if (ack_cyc != t0 + 2 + int'(TO_CYC) || er !== 1'b1 || rd !== 32'h0) begin
            tests_failed++; $display("FAIL timeout: got ack %0d err %b data %h, expected %0d 1 0", ack_cyc, er, rd, t0 + 2 + int'(TO_CYC));
        end
        step();
        delay_cfg = int'(TO_CYC) - 1;
        a = 23'($urandom);
        req0 = 1'b1; addr0 = a; t0 = cyc + 1; ack_cyc = -1;
        for (int i = 0; i < 40 && ack_cyc < 0; i++) begin
            step();
            if (ack0) begin ack_cyc = cyc; rd = rdata0; er = err0; req0 = 1'b0; end
        end
        req0 = 1'b0; delay_cfg = 0;
        model_last = 1'b0;
        tests_run++;
        if (ack_cyc != t0 + 2 + int'(TO_CYC) || er !== 1'b0 || rd !== mem_word(a)) begin
            tests_failed++; $display("FAIL timeout_race: got ack %0d err %b data %h, expected %0d 0 %h", ack_cyc, er, rd, t0 + 2 + int'(TO_CYC), mem_word(a));
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_alternate(8);
        test_stall();
        test_back_to_back();
        test_spurious_rdv();
`ifdef FLASH_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/flash_read_arbiter.md
# flash_read_arbiter

- Shares the single flash read port between two requesters:
  - port 0: the audio playback sequencer.
  - port 1: a secondary reader, e.g. a metadata or display fetcher.
- Runs one outstanding read at a time on a pipelined, Avalon-style flash master interface, using waitrequest and readdatavalid.
- Round-robin arbitration between the ports; port 0 wins when there is no history.
- Sits between the playback/auxiliary FSMs and the flash controller.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: cycles to wait for readdatavalid before aborting. Used only when FLASH_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1 each  read request, held until the matching ack.
- addr0, addr1  in  23 each  flash address, stable while req is high.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- rdata0, rdata1  out  32 each  read data, valid in the ack cycle.
- err0, err1  out  1 each  timeout flag, pulsed with ack.
- flash_mem_read  out  1  read strobe to the flash controller.
- flash_mem_address  out  23  read address.
- flash_mem_byteenable  out  4  constant 4'hF.
- flash_mem_waitrequest  in  1  controller stall.
- flash_mem_readdata  in  32  returned data.
- flash_mem_readdatavalid  in  1  returned-data qualifier.
- busy  out  1  high in every state except IDLE.

## Operation
States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req is high, select a winner and latch its address into flash_mem_address and its id into gnt_id; go to ISSUE.
  - Winner when both req0 and req1 are high: the port other than last_id.
  - last_id resets to 1, so port 0 wins the first contention.
- **ISSUE**
  - flash_mem_read = 1.
  - When flash_mem_waitrequest = 0 on a clock edge: the command is accepted; go to WAIT.
- **WAIT**
  - flash_mem_read = 0.
  - On flash_mem_readdatavalid: capture flash_mem_readdata; go to RESP.
- **RESP**
  - Drive ack[gnt_id] = 1, rdata[gnt_id] = captured data, err[gnt_id] = 0.
  - Set last_id = gnt_id; go to IDLE.
- Non-granted port: ack, err and rdata hold their previous values (rdata) or 0 (ack, err).
- Address is passed through unmodified; no alignment or arithmetic.
- A requester must not drop req, or change addr, between sampling and ack. If it does, the transaction still completes and ack still pulses.
- flash_mem_readdatavalid outside WAIT is ignored: no capture, no state change.

Reset values (all outputs and state):
- flash_mem_read = 0, flash_mem_address = 0, flash_mem_byteenable = 4'hF.
- ack0/1 = 0, err0/1 = 0, rdata0/1 = 0, busy = 0.
- state = IDLE, last_id = 1, timeout counter = 0.

## Timing
- Request sampled in IDLE at edge N; flash_mem_read is high from N+1.
- Best case (waitrequest = 0 at N+1, readdatavalid at N+2): ack at N+3. Minimum latency is 3 cycles.
- Each waitrequest cycle and each readdatavalid delay cycle adds one cycle.
- After an ack, the next grant is decided in the following IDLE cycle.
- Back-to-back reads from one port: a new req sampled 1 cycle after ack gives 4 cycles per read.
- Both ports continuously requesting: grants strictly alternate 0, 1, 0, 1, ...
- Reset asserted mid-transaction:
  - At the next edge, go to IDLE with flash_mem_read = 0.
  - No ack is issued for the aborted read.
  - A late readdatavalid from that read is ignored.

## Configuration
FLASH_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If the count reaches TIMEOUT_CYCLES with no readdatavalid, go to RESP with rdata = 32'h0 and err = 1 for the granted port.
  - A readdatavalid in the same cycle the count reaches TIMEOUT_CYCLES wins: normal data, err = 0.
- Not defined: no counter; WAIT can last indefinitely; err0/err1 are tied to 0.

## Test plan
- req0 = 1, addr0 = 23'h000100, waitrequest = 0, readdatavalid one cycle after accept with data 32'hA5A5_1234 → flash_mem_address = 23'h000100, single-cycle read strobe; ack0 with rdata0 = 32'hA5A5_1234 three cycles after sampling; ack1 stays 0.
- req0 and req1 raised in the same cycle, held for 4 transactions → grant order 0, 1, 0, 1; each ack carries its own address's data.
- waitrequest held high 5 cycles in ISSUE → flash_mem_read stays high for 6 cycles, address stable; ack arrives 5 cycles later than best case.
- reset in WAIT, then readdatavalid 2 cycles later → no ack, busy = 0; next req1 with addr1 = 23'h7FFFC completes normally.
- With FLASH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, readdatavalid never asserted → ack0 = 1, err0 = 1, rdata0 = 0 after 8 WAIT cycles.
- readdatavalid pulsed while IDLE → no state change, no ack.
